// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator with zero padding at the image borders.
// Two line buffers feed a register window; a FLUSH phase drains the final rows.
module window_gen3x3 #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_ready,
  output logic [9*DATA_W-1:0]   o_busData,
  output logic                  o_valid,
  output logic                  o_last
);

  localparam int unsigned PIX_N = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(PIX_N + 1);
  localparam int unsigned FL_W  = $clog2(IMG_W + 1);
  localparam int unsigned PTR_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   in_cnt_q;
  logic [FL_W-1:0]    fl_cnt_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [ROW_W-1:0]   cen_row_q;
  logic [PTR_W-1:0]   cen_col_q;
  logic [DATA_W-1:0]  col_a_q [3];
  logic [DATA_W-1:0]  col_b_q [3];
  logic [DATA_W-1:0]  lb_mid [IMG_W];
  logic [DATA_W-1:0]  lb_top [IMG_W];

  logic [DATA_W-1:0]  pix_d;
  logic [DATA_W-1:0]  newcol_d [3];
  logic [9*DATA_W-1:0] bus_d;
  logic [2:0]         row_ok_d;
  logic [2:0]         col_ok_d;
  logic               shift_d;
  logic               emit_d;
  logic [DATA_W-1:0]  raw_d;

  // New column, border mask and padded window for the window being emitted.
  always_comb begin
    shift_d     = (state_q == FLUSH) | i_valid;
    emit_d      = (state_q == FLUSH) | ((state_q == RUN) & i_valid);
    pix_d       = (state_q == FLUSH) ? '0 : i_data;
    newcol_d[0] = lb_top[ptr_q];
    newcol_d[1] = lb_mid[ptr_q];
    newcol_d[2] = pix_d;
    row_ok_d    = {cen_row_q != ROW_W'(IMG_H - 1), 1'b1, cen_row_q != '0};
    col_ok_d    = {cen_col_q != PTR_W'(IMG_W - 1), 1'b1, cen_col_q != '0};
    bus_d       = '0;
    raw_d       = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0)      raw_d = col_a_q[r];
        else if (c == 1) raw_d = col_b_q[r];
        else             raw_d = newcol_d[r];
        if (row_ok_d[r] && col_ok_d[c])
          bus_d[(r*3+c)*DATA_W +: DATA_W] = raw_d;
      end
    end
  end

  // Line buffers are plain delay RAMs; stale contents are hidden by the mask.
  always_ff @(posedge i_clk) begin
    if (shift_d) begin
      lb_mid[ptr_q] <= pix_d;
      lb_top[ptr_q] <= lb_mid[ptr_q];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= FILL;
      in_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      ptr_q     <= '0;
      cen_row_q <= '0;
      cen_col_q <= '0;
      for (int r = 0; r < 3; r++) begin
        col_a_q[r] <= '0;
        col_b_q[r] <= '0;
      end
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_busData <= '0;
    end else begin
      o_valid <= emit_d;
      o_last  <= 1'b0;
      if (emit_d) begin
        o_busData <= bus_d;
        if (cen_col_q == PTR_W'(IMG_W - 1)) begin
          cen_col_q <= '0;
          cen_row_q <= (cen_row_q == ROW_W'(IMG_H - 1)) ? '0 : cen_row_q + 1'b1;
        end else begin
          cen_col_q <= cen_col_q + 1'b1;
        end
      end
      if (shift_d) begin
        for (int r = 0; r < 3; r++) begin
          col_a_q[r] <= col_b_q[r];
          col_b_q[r] <= newcol_d[r];
        end
        ptr_q <= (ptr_q == PTR_W'(IMG_W - 1)) ? '0 : ptr_q + 1'b1;
      end
      case (state_q)
        FILL: begin
          if (i_valid) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == CNT_W'(IMG_W)) state_q <= RUN;
          end
        end
        RUN: begin
          if (i_valid) begin
            if (in_cnt_q == CNT_W'(PIX_N - 1)) begin
              state_q  <= FLUSH;
              fl_cnt_q <= '0;
              o_ready  <= 1'b0;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          fl_cnt_q <= fl_cnt_q + 1'b1;
          if (fl_cnt_q == FL_W'(IMG_W)) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            fl_cnt_q  <= '0;
            ptr_q     <= '0;
            cen_row_q <= '0;
            cen_col_q <= '0;
            o_ready   <= 1'b1;
            o_last    <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_window_gen3x3.sv
// Scoreboard bench for window_gen3x3 on a 4x4 image with 10-bit pixels.
module tb_window_gen3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 10;
  localparam int BW = 9 * DW;

  typedef struct {
    logic [BW-1:0] bus;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic [BW-1:0] o_busData;
  logic          o_valid;
  logic          o_last;

  window_gen3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_busData(o_busData), .o_valid(o_valid), .o_last(o_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt, lcnt, rlow;
  int first_valid_cyc, last_cyc, acc5_cyc, acc16_cyc;
  logic [BW-1:0] got [64];
  exp_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] exp_win(input int base, input int r, input int c);
    logic [BW-1:0] v = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          v[((dr+1)*3 + (dc+1))*DW +: DW] = DW'(base + rr*W + cc + 1);
      end
    return v;
  endfunction

  function automatic logic [BW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  task automatic push_frame(input int base);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.bus  = exp_win(base, r, c);
        e.last = (r == H-1) && (c == W-1);
        sb.push_back(e);
      end
  endtask

  // Output monitor: every window is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!o_ready) rlow++;
    if (o_valid) begin
      if (vcnt == 0) first_valid_cyc = cyc;
      if (vcnt < 64) got[vcnt] = o_busData;
      if (o_last && lcnt == 0) last_cyc = cyc;
      if (o_last) lcnt++;
      vcnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra window %0d got %h with nothing expected", vcnt, o_busData);
      end else begin
        e = sb.pop_front();
        if (o_busData !== e.bus || o_last !== e.last) begin
          errors++;
          $display("FAIL sb_window %0d got %h last %b, want %h last %b",
                   vcnt-1, o_busData, o_last, e.bus, e.last);
        end
      end
    end
  end

  task automatic clear_stats();
    vcnt = 0; lcnt = 0; rlow = 0;
    first_valid_cyc = -1; last_cyc = -1; acc5_cyc = -1; acc16_cyc = -1;
  endtask

  task automatic drive(input int base0, input int npix, input bit toggle);
    int idx = 0;
    int guard = 0;
    int ph = 0;
    bit acc;
    while (idx < npix && guard < 1000) begin
      i_valid = toggle ? (ph % 2 == 0) : 1'b1;
      ph++;
      i_data  = DW'(base0 + 100*(idx/16) + idx%16 + 1);
      acc     = i_valid && o_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (idx == 5)  acc5_cyc  = cyc;
        if (idx == 16) acc16_cyc = cyc;
        idx++;
      end
      guard++;
    end
    i_valid = 1'b0;
    checks++;
    if (idx != npix) begin
      errors++;
      $display("FAIL drive_accept accepted %0d pixels, want %0d", idx, npix);
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((sb.size() != 0 || !o_ready) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout %0d windows still pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_data = '0;
    @(negedge clk);
    checks += 4;
    if (o_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got %b want 1", o_ready); end
    if (o_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
    if (o_last !== 1'b0)    begin errors++; $display("FAIL rst_last got %b want 0", o_last); end
    if (o_busData !== '0)   begin errors++; $display("FAIL rst_bus got %h want 0", o_busData); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_counts(input string tag, input int nv, input int nr);
    checks += 3;
    if (vcnt != nv) begin errors++; $display("FAIL %s_valid_count got %0d want %0d", tag, vcnt, nv); end
    if (rlow != nr) begin errors++; $display("FAIL %s_ready_low got %0d want %0d", tag, rlow, nr); end
    if (lcnt != nv/16) begin errors++; $display("FAIL %s_last_count got %0d want %0d", tag, lcnt, nv/16); end
  endtask

  task automatic test_stream();
    clear_stats();
    push_frame(0);
    drive(0, 16, 1'b0);
    wait_done();
    frame_counts("stream", 16, 5);
    checks += 5;
    if (first_valid_cyc != acc5_cyc) begin errors++; $display("FAIL first_valid_latency got cycle %0d want %0d", first_valid_cyc, acc5_cyc); end
    if (got[0] !== pk(0,0,0,0,1,2,0,5,6)) begin errors++; $display("FAIL win_0_0 got %h want %h", got[0], pk(0,0,0,0,1,2,0,5,6)); end
    if (got[5] !== pk(1,2,3,5,6,7,9,10,11)) begin errors++; $display("FAIL win_1_1 got %h want %h", got[5], pk(1,2,3,5,6,7,9,10,11)); end
    if (got[3] !== pk(0,0,0,3,4,0,7,8,0)) begin errors++; $display("FAIL win_0_3 got %h want %h", got[3], pk(0,0,0,3,4,0,7,8,0)); end
    if (got[15] !== pk(11,12,0,15,16,0,0,0,0)) begin errors++; $display("FAIL win_3_3 got %h want %h", got[15], pk(11,12,0,15,16,0,0,0,0)); end
  endtask

  task automatic test_toggle();
    clear_stats();
    push_frame(0);
    drive(0, 16, 1'b1);
    wait_done();
    frame_counts("toggle", 16, 5);
  endtask

  task automatic test_back_to_back();
    clear_stats();
    push_frame(0);
    push_frame(100);
    drive(0, 32, 1'b0);
    wait_done();
    frame_counts("b2b", 32, 10);
    checks += 2;
    if (acc16_cyc != last_cyc + 1) begin errors++; $display("FAIL b2b_restart got cycle %0d want %0d", acc16_cyc, last_cyc + 1); end
    if (got[16] !== pk(0,0,0,0,101,102,0,105,106)) begin errors++; $display("FAIL b2b_win_0_0 got %h want %h", got[16], pk(0,0,0,0,101,102,0,105,106)); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    push_frame(0);
    drive(0, 9, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks += 3;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", o_valid); end
      if (o_last !== 1'b0)  begin errors++; $display("FAIL mid_rst_last got %b want 0", o_last); end
      if (o_busData !== '0) begin errors++; $display("FAIL mid_rst_bus got %h want 0", o_busData); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    clear_stats();
    push_frame(0);
    drive(0, 16, 1'b0);
    wait_done();
    frame_counts("mid_rst", 16, 5);
    checks++;
    if (got[0] !== pk(0,0,0,0,1,2,0,5,6)) begin errors++; $display("FAIL mid_rst_win_0_0 got %h want %h", got[0], pk(0,0,0,0,1,2,0,5,6)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
